// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Default widths, request bundle, round-robin side and a saturating adder.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } rr_side_e;

  // Add up to two drops to an 8-bit counter, sticking at 255.
  function automatic logic [7:0] sat_add8(
    input logic [7:0] a,
    input logic [1:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding buffer.
// Ready is a pure decode of the valid flag so no input reaches it.
import regfile_pkg::*;

module wb_hold_slot #(
  parameter type req_t = wb_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  req_t req_i,
  input  logic clear_i,
  output logic valid_o,
  output logic ready_o,
  output req_t req_o
);

  logic valid_q;
  req_t req_q;

  // Occupancy: load only lands when empty, clear only when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  // Payload capture on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (load_i) begin
      req_q <= req_i;
    end
  end

  assign valid_o = valid_q;
  assign ready_o = !valid_q;
  assign req_o   = req_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port between the ALU
// and load writeback paths, with r0 filtering and RAW hazard flags.
import regfile_pkg::*;

module regfile_write_arbiter #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              zero_write_err,
  output logic [7:0]        drop_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic     a_take, a_zero, a_load;
  logic     b_take, b_zero, b_load;
  logic     hold_a_vld, hold_b_vld;
  req_t     hold_a_req, hold_b_req;
  req_t     a_in, b_in;
  logic     grant_a, grant_b;
  rr_side_e rr_q, rr_d;
  logic     regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic     zerr_q;
  logic [7:0] drop_q;

  assign a_take = a_valid & a_ready;
  assign a_zero = a_take & (a_reg == ZERO_ADDR);
  assign a_load = a_take & ~a_zero;
  assign b_take = b_valid & b_ready;
  assign b_zero = b_take & (b_reg == ZERO_ADDR);
  assign b_load = b_take & ~b_zero;

  assign a_in = '{rd: a_reg, data: a_data};
  assign b_in = '{rd: b_reg, data: b_data};

  wb_hold_slot #(.req_t(req_t)) u_hold_a (
    .clk     (clock),
    .rst_n   (reset_n),
    .load_i  (a_load),
    .req_i   (a_in),
    .clear_i (grant_a),
    .valid_o (hold_a_vld),
    .ready_o (a_ready),
    .req_o   (hold_a_req)
  );

  wb_hold_slot #(.req_t(req_t)) u_hold_b (
    .clk     (clock),
    .rst_n   (reset_n),
    .load_i  (b_load),
    .req_i   (b_in),
    .clear_i (grant_b),
    .valid_o (hold_b_vld),
    .ready_o (b_ready),
    .req_o   (hold_b_req)
  );

  // A lone holder always wins; a tie goes to the pointer's side.
  assign grant_a = hold_a_vld & (~hold_b_vld | (rr_q == SIDE_A));
  assign grant_b = hold_b_vld & (~hold_a_vld | (rr_q == SIDE_B));

  // Pointer only moves after a contended grant.
  always_comb begin
    rr_d = rr_q;
    if (hold_a_vld && hold_b_vld) begin
      rr_d = (rr_q == SIDE_A) ? SIDE_B : SIDE_A;
    end
  end

  // Output stage next state; address/data hold when idle.
  always_comb begin
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    unique case (1'b1)
      grant_a: begin
        regwrite_d = 1'b1;
        wreg_d     = hold_a_req.rd;
        wdata_d    = hold_a_req.data;
      end
      grant_b: begin
        regwrite_d = 1'b1;
        wreg_d     = hold_b_req.rd;
        wdata_d    = hold_b_req.data;
      end
      default: ;
    endcase
  end

  // Registered write port and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      rr_q       <= SIDE_A;
    end else begin
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      rr_q       <= rr_d;
    end
  end

  // Dropped r0 writes: single pulse, counter may step by two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zerr_q <= 1'b0;
      drop_q <= '0;
    end else begin
      zerr_q <= a_zero | b_zero;
      drop_q <= sat_add8(drop_q, {1'b0, a_zero} + {1'b0, b_zero});
    end
  end

  function automatic logic hz(input logic [ADDR_W-1:0] rr);
    return (rr != ZERO_ADDR) &
           ((hold_a_vld & (hold_a_req.rd == rr)) |
            (hold_b_vld & (hold_b_req.rd == rr)) |
            (regwrite_q & (wreg_q == rr)));
  endfunction

  assign hazard1        = hz(read_reg1);
  assign hazard2        = hz(read_reg2);
  assign RegWrite       = regwrite_q;
  assign write_reg      = wreg_q;
  assign write_data     = wdata_q;
  assign zero_write_err = zerr_q;
  assign drop_count     = drop_q;

endmodule
